// File: rtl/seg7_bcd_capture.sv
// Rebuilds the BCD value shown on a 4-digit multiplexed 7-segment bus.
// Define SEG7_CAP_HEX_EN to add A-F decode (6 then only as 0x7D, 9 only as 0x6F).
module seg7_bcd_capture #(
   parameter int unsigned STABLE_CYC = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [6:0]  SEG,
   input  logic [3:0]  AN,
   input  logic        COMC,
   output logic [15:0] DIGITS,
   output logic [3:0]  BLANK,
   output logic        FRAME_VLD,
   output logic        FRAME_ERR
);

   typedef enum logic [1:0] {SCAN, SETTLE, HOLD} state_t;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

   state_t      state;
   logic [11:0] p;
   logic [11:0] p_prev;
   logic [7:0]  cnt;
   logic [3:0]  mask;
   logic [3:0]  blank_b;
   logic [3:0]  err_b;
   logic [15:0] slots;

   logic [3:0]  an_p;
   logic [6:0]  seg_cc;
   logic        change;
   logic        onehot;
   logic [1:0]  idx;
   logic [3:0]  dec_val;
   logic        dec_blank;
   logic        dec_err;
   logic [15:0] slots_n;
   logic [3:0]  blank_n;
   logic [3:0]  err_n;
   logic [3:0]  mask_n;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p      <= '0;
         p_prev <= '0;
      end else begin
         p      <= {COMC, AN, SEG};
         p_prev <= p;
      end
   end

   assign an_p   = p[10:7];
   assign seg_cc = p[11] ? p[6:0] : ~p[6:0];
   assign change = (p != p_prev);
   assign onehot = (an_p != '0) && ((an_p & (an_p - 4'd1)) == '0);

   always_comb begin
      idx = 2'd0;
      case (an_p)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   always_comb begin
      dec_val   = '0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (seg_cc)
         7'h3F: dec_val = 4'd0;
         7'h06: dec_val = 4'd1;
         7'h5B: dec_val = 4'd2;
         7'h4F: dec_val = 4'd3;
         7'h66: dec_val = 4'd4;
         7'h6D: dec_val = 4'd5;
         7'h07: dec_val = 4'd7;
         7'h7F: dec_val = 4'd8;
`ifdef SEG7_CAP_HEX_EN
         7'h7D: dec_val = 4'd6;
         7'h6F: dec_val = 4'd9;
         7'h77: dec_val = 4'hA;
         7'h7C: dec_val = 4'hB;
         7'h39: dec_val = 4'hC;
         7'h5E: dec_val = 4'hD;
         7'h79: dec_val = 4'hE;
         7'h71: dec_val = 4'hF;
`else
         7'h7C, 7'h7D: dec_val = 4'd6;
         7'h67, 7'h6F: dec_val = 4'd9;
`endif
         7'h00:   dec_blank = 1'b1;
         default: dec_err   = 1'b1;
      endcase
   end

   // Frame contents as they would be after this capture; the publish uses these
   // so the fourth digit lands in DIGITS on the same edge it is captured.
   always_comb begin
      slots_n                     = slots;
      slots_n[{idx, 2'b00} +: 4]  = dec_val;
      blank_n                     = blank_b;
      blank_n[idx]                = dec_blank;
      err_n                       = err_b;
      err_n[idx]                  = dec_err;
      mask_n                      = mask;
      mask_n[idx]                 = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= SCAN;
         cnt       <= '0;
         mask      <= '0;
         blank_b   <= '0;
         err_b     <= '0;
         slots     <= '0;
         DIGITS    <= '0;
         BLANK     <= '0;
         FRAME_VLD <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         FRAME_VLD <= 1'b0;
         case (state)
            SCAN: begin
               if (onehot) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end
            end
            SETTLE: begin
               if (change) begin
                  state <= onehot ? SETTLE : SCAN;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= HOLD;
                  slots   <= slots_n;
                  blank_b <= blank_n;
                  if (mask_n == 4'hF) begin
                     DIGITS    <= slots_n;
                     BLANK     <= blank_n;
                     FRAME_ERR <= |err_n;
                     FRAME_VLD <= 1'b1;
                     mask      <= '0;
                     err_b     <= '0;
                  end else begin
                     mask  <= mask_n;
                     err_b <= err_n;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HOLD: begin
               if (change) begin
                  state <= onehot ? SETTLE : SCAN;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= SCAN;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Directed bench for seg7_bcd_capture (STABLE_CYC=4); follows SEG7_CAP_HEX_EN for hex expectations.
module tb_seg7_bcd_capture;

   logic        CLK = 1'b0;
   logic        RST;
   logic [6:0]  SEG;
   logic [3:0]  AN;
   logic        COMC;
   logic [15:0] DIGITS;
   logic [3:0]  BLANK;
   logic        FRAME_VLD;
   logic        FRAME_ERR;

   int checks   = 0;
   int failures = 0;
   int vld_cnt  = 0;

   always #5 CLK = ~CLK;

   seg7_bcd_capture #(.STABLE_CYC(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SEG      (SEG),
      .AN       (AN),
      .COMC     (COMC),
      .DIGITS   (DIGITS),
      .BLANK    (BLANK),
      .FRAME_VLD(FRAME_VLD),
      .FRAME_ERR(FRAME_ERR)
   );

   always @(negedge CLK) if (FRAME_VLD === 1'b1) vld_cnt++;

   // Present one strobe window for n clocks; returns 1 time unit after a rising edge.
   task automatic win(input logic [3:0] an, input logic [6:0] seg, input int n);
      AN  = an;
      SEG = seg;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1; AN = 4'b0001; SEG = 7'h06; COMC = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (DIGITS !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", DIGITS); end
      checks++; if (BLANK !== 4'h0) begin failures++; $display("FAIL reset_blank got=%b exp=0000", BLANK); end
      checks++; if (FRAME_VLD !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", FRAME_VLD); end
      checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", FRAME_ERR); end
      AN = 4'b0000; SEG = 7'h00;
      RST = 1'b0;
      win(4'b0000, 7'h00, 3);
   endtask

   task automatic test_basic;
      int v0;
      v0 = vld_cnt;
      COMC = 1'b1;
      win(4'b0001, 7'h4F, 10);
      win(4'b0010, 7'h5B, 10);
      win(4'b0100, 7'h06, 10);
      win(4'b1000, 7'h3F, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL basic_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== 16'h0123) begin failures++; $display("FAIL basic_digits got=%h exp=0123", DIGITS); end
      checks++; if (BLANK !== 4'b0000) begin failures++; $display("FAIL basic_blank got=%b exp=0000", BLANK); end
      checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", FRAME_ERR); end
   endtask

   task automatic test_blank_err;
      int v0;
      v0 = vld_cnt;
      win(4'b0001, 7'h3F, 10);
      win(4'b0010, 7'h06, 10);
      win(4'b0100, 7'h00, 10);
      win(4'b1000, 7'h55, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL blank_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== 16'h0010) begin failures++; $display("FAIL blank_digits got=%h exp=0010", DIGITS); end
      checks++; if (BLANK !== 4'b0100) begin failures++; $display("FAIL blank_mask got=%b exp=0100", BLANK); end
      checks++; if (FRAME_ERR !== 1'b1) begin failures++; $display("FAIL blank_err got=%b exp=1", FRAME_ERR); end
   endtask

   task automatic test_alt_forms;
      int v0;
      v0 = vld_cnt;
      win(4'b0001, 7'h7D, 10);
      win(4'b0010, 7'h6F, 10);
      win(4'b0100, 7'h7F, 10);
      win(4'b1000, 7'h6D, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL alt_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== 16'h5896) begin failures++; $display("FAIL alt_digits got=%h exp=5896", DIGITS); end
      checks++; if (BLANK !== 4'b0000) begin failures++; $display("FAIL alt_blank got=%b exp=0000", BLANK); end
      checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL alt_err got=%b exp=0", FRAME_ERR); end
   endtask

   task automatic test_comc0;
      int v0;
      logic [15:0] exp_d;
      logic        exp_e;
`ifdef SEG7_CAP_HEX_EN
      exp_d = 16'hB780; exp_e = 1'b1;
`else
      exp_d = 16'h6789; exp_e = 1'b0;
`endif
      v0 = vld_cnt;
      COMC = 1'b0;
      win(4'b0000, 7'h7F, 3);
      win(4'b0001, ~7'h67, 10);
      win(4'b0010, ~7'h7F, 10);
      win(4'b0100, ~7'h07, 10);
      win(4'b1000, ~7'h7C, 10);
      win(4'b0000, 7'h7F, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL comc0_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== exp_d) begin failures++; $display("FAIL comc0_digits got=%h exp=%h", DIGITS, exp_d); end
      checks++; if (FRAME_ERR !== exp_e) begin failures++; $display("FAIL comc0_err got=%b exp=%b", FRAME_ERR, exp_e); end
      COMC = 1'b1;
      win(4'b0000, 7'h00, 3);
   endtask

   task automatic test_glitch;
      int v0;
      v0 = vld_cnt;
      win(4'b0001, 7'h06, 3);
      win(4'b0000, 7'h00, 4);
      win(4'b0010, 7'h6D, 10);
      win(4'b0100, 7'h66, 10);
      win(4'b1000, 7'h07, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0) begin failures++; $display("FAIL glitch_no_frame got=%0d exp=%0d", vld_cnt - v0, 0); end
      win(4'b0001, 7'h06, 6);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL glitch_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== 16'h7451) begin failures++; $display("FAIL glitch_digits got=%h exp=7451", DIGITS); end
      checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b exp=0", FRAME_ERR); end
   endtask

   // Fourth-digit capture and FRAME_VLD land on the 6th edge after presentation.
   task automatic test_latency;
      int first_k;
      int width;
      first_k = 0;
      width   = 0;
      win(4'b0001, 7'h06, 10);
      win(4'b0010, 7'h5B, 10);
      win(4'b0100, 7'h4F, 10);
      AN = 4'b1000; SEG = 7'h7F;
      for (int k = 1; k <= 10; k++) begin
         @(posedge CLK);
         #1;
         if (FRAME_VLD === 1'b1) begin
            width++;
            if (first_k == 0) first_k = k;
         end
      end
      win(4'b0000, 7'h00, 3);
      checks++; if (first_k !== 6) begin failures++; $display("FAIL latency_edge got=%0d exp=%0d", first_k, 6); end
      checks++; if (width !== 1) begin failures++; $display("FAIL latency_pulse_width got=%0d exp=%0d", width, 1); end
      checks++; if (DIGITS !== 16'h8321) begin failures++; $display("FAIL latency_digits got=%h exp=8321", DIGITS); end
   endtask

   task automatic test_scan_reset;
      int v0;
      v0 = vld_cnt;
      win(4'b0011, 7'h06, 20);
      win(4'b0010, 7'h5B, 10);
      win(4'b0100, 7'h4F, 10);
      win(4'b1000, 7'h66, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0) begin failures++; $display("FAIL scan_no_capture got=%0d exp=%0d", vld_cnt - v0, 0); end
      win(4'b0001, 7'h3F, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL scan_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== 16'h4320) begin failures++; $display("FAIL scan_digits got=%h exp=4320", DIGITS); end

      win(4'b0001, 7'h6D, 10);
      win(4'b0010, 7'h7D, 10);
      #2;
      RST = 1'b1;
      AN  = 4'b0000;
      SEG = 7'h00;
      #1;
      checks++; if (DIGITS !== 16'h0000) begin failures++; $display("FAIL async_rst_digits got=%h exp=0000", DIGITS); end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      win(4'b0000, 7'h00, 3);
      v0 = vld_cnt;
      win(4'b0100, 7'h07, 10);
      win(4'b1000, 7'h7F, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0) begin failures++; $display("FAIL rst_partial_discard got=%0d exp=%0d", vld_cnt - v0, 0); end
      win(4'b0001, 7'h06, 10);
      win(4'b0010, 7'h4F, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL rst_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== 16'h8731) begin failures++; $display("FAIL rst_digits got=%h exp=8731", DIGITS); end
   endtask

   task automatic test_hex;
      int v0;
      logic [15:0] exp_d;
      logic        exp_e;
`ifdef SEG7_CAP_HEX_EN
      exp_d = 16'hDCBA; exp_e = 1'b0;
`else
      exp_d = 16'h0060; exp_e = 1'b1;
`endif
      v0 = vld_cnt;
      win(4'b0001, 7'h77, 10);
      win(4'b0010, 7'h7C, 10);
      win(4'b0100, 7'h39, 10);
      win(4'b1000, 7'h5E, 10);
      win(4'b0000, 7'h00, 3);
      checks++; if (vld_cnt !== v0 + 1) begin failures++; $display("FAIL hex_vld_count got=%0d exp=%0d", vld_cnt - v0, 1); end
      checks++; if (DIGITS !== exp_d) begin failures++; $display("FAIL hex_digits got=%h exp=%h", DIGITS, exp_d); end
      checks++; if (FRAME_ERR !== exp_e) begin failures++; $display("FAIL hex_err got=%b exp=%b", FRAME_ERR, exp_e); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blank_err();
      test_alt_forms();
      test_comc0();
      test_glitch();
      test_latency();
      test_scan_reset();
      test_hex();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_bcd_capture.md
Name: seg7_bcd_capture

Overview:
- Receive-side counterpart of the cd4511 BCD-to-7-segment path: monitors a 4-digit multiplexed 7-segment bus (segment lines plus digit strobes) and rebuilds the displayed BCD value.
- Each strobe window is settle-filtered, and the pattern is decoded back to BCD. A whole-frame result is published once all four digits have been captured.
- Used as a self-check/readback block next to the display driver and in display-loopback benches.

Parameters:
- STABLE_CYC, 4, consecutive unchanged registered-input cycles required before a digit is captured; legal range 1..255.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- SEG  input  7  segment lines {g,f,e,d,c,b,a}; SEG[0]=a.
- AN  input  4  digit strobes, active-high; AN[i] selects digit i.
- COMC  input  1  1 = common-cathode (segment on = 1); 0 = common-anode. SEG is inverted before decode when COMC=0.
- DIGITS  output  16  captured BCD; digit i at [4i+3:4i].
- BLANK  output  4  bit i set = digit i was blank in the last frame.
- FRAME_VLD  output  1  one-cycle pulse when DIGITS, BLANK and FRAME_ERR update.
- FRAME_ERR  output  1  last published frame contained an undecodable pattern.

Behaviour:
- Reset: all outputs 0; internal mask, slots and counter cleared; FSM = SCAN; input register cleared.
- Input stage:
  - One register stage on {COMC,AN,SEG}; all decisions use the registered copy P.
  - "Change" means P differs from its previous cycle value.
- Decode (common-cathode polarity after COMC correction):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7C or 0x7D→6, 0x07→7, 0x7F→8, 0x67 or 0x6F→9.
  - 0x00 → blank: slot 0, blank bit set.
  - Any other pattern → invalid: slot 0, error bit set.
- FSM states:
  - SCAN: AN is not one-hot (0 or multiple bits). Stay here until AN is one-hot, then go to SETTLE with cnt=0.
  - SETTLE: a change while AN is one-hot restarts SETTLE with cnt=0; a change to non-one-hot AN goes to SCAN. Otherwise cnt increments. On the cycle where cnt==STABLE_CYC-1 and there is no change, capture and go to HOLD.
  - HOLD: ignore further cycles of the same P. Any change goes to SETTLE (one-hot) or SCAN (not one-hot). One capture per strobe window.
- Capture: write the decoded slot, blank bit and error bit for index i = onehot(AN), then set mask[i].
  - Recapturing a digit already in the mask overwrites its slot; the mask is unchanged.
- Frame publish: on the capture edge where (mask | 1<<i)==4'hF:
  - Load DIGITS, BLANK and FRAME_ERR (OR of the four error bits), including the current capture.
  - Pulse FRAME_VLD for 1 cycle.
  - Clear the mask and error bits.
- Outputs hold between publishes.
- Latency: a pin change that then stays stable is captured STABLE_CYC+1 clocks after the edge that presents it. FRAME_VLD asserts on that same edge for the fourth digit.
- Boundaries:
  - A window shorter than STABLE_CYC cycles is never captured and does not contribute to the frame.
  - A COMC change counts as a change.
  - Asynchronous RST mid-frame discards the partial frame immediately.

Optional Feature:
- Macro: SEG7_CAP_HEX_EN.
- Defined:
  - Adds hex decode: 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F.
  - 6 is accepted only as 0x7D; 9 only as 0x6F.
- Undefined:
  - Plain BCD decode as above; 0x7C decodes as 6.
  - The A–F patterns other than 0x7C are invalid.

Test Plan:
- STABLE_CYC=4, COMC=1: strobe AN=0001/0010/0100/1000 with 0x4F,0x5B,0x06,0x3F, 10 cycles each → one FRAME_VLD, DIGITS=16'h0123, BLANK=0, FRAME_ERR=0.
- COMC=0 with inverted patterns of digits 9,8,7,6 (cd4511 forms 0x67,0x7F,0x07,0x7C) → DIGITS=16'h6789, FRAME_ERR=0.
- Glitch: AN=0001 SEG=0x06 held 3 cycles only, then AN=0000 → no capture, mask unchanged; a following 6-cycle window captures 1.
- Pattern 0x00 on digit 2 and 0x55 on digit 3, others valid → BLANK=4'b0100, slots 2 and 3 = 0, FRAME_ERR=1.
- AN=0011 held 20 cycles → FSM stays in SCAN, no capture. Assert RST after 2 digits captured, then present 4 digits → first FRAME_VLD reflects only post-reset digits.
- SEG7_CAP_HEX_EN defined: patterns 0x77,0x7C,0x39,0x5E on digits 0..3 → DIGITS=16'hDCBA, FRAME_ERR=0. Undefined: same stimulus → FRAME_ERR=1, DIGITS[7:4]=6.
